// File: rtl/pwm_pkg.sv
// Shared defaults, update-handshake state encoding and sample-to-duty conversion
// for the multi-channel PWM block.
package pwm_pkg;

  localparam int unsigned CH_DEFAULT    = 2;
  localparam int unsigned SRC_W_DEFAULT = 16;
  localparam int unsigned W_DEFAULT     = 12;
  localparam int unsigned DIV_DEFAULT   = 4;

  typedef enum logic {
    UPD_IDLE    = 1'b0,
    UPD_PENDING = 1'b1
  } upd_state_e;

  // Keep the top w bits of a src_w-bit signed sample and flip the sign bit,
  // turning two's complement into offset binary (0x8000.. -> 0, 0x0000.. -> mid).
  function automatic logic [31:0] to_offset_bin(input logic [31:0] sample,
                                                input int unsigned src_w,
                                                input int unsigned w);
    logic [31:0] duty;
    duty = sample >> (src_w - w);
    duty = duty & ((32'd1 << w) - 32'd1);
    duty = duty ^ (32'd1 << (w - 1));
    return duty;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: counts 0..DIV-1 while enabled and flags the last count.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = enable && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (!enable || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM with a shared prescaler/counter and shadowed duty updates
// that only take effect at a period wrap (or immediately while stopped).
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int unsigned CH    = CH_DEFAULT,
  parameter int unsigned SRC_W = SRC_W_DEFAULT,
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned DIV   = DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [CH*SRC_W-1:0]   din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [CH-1:0]         pwm_out,
  output logic                  period_tick
);

  logic          tick;
  logic          wrap;
  logic          xfer;
  logic          load;
  logic [W-1:0]  cnt_q, cnt_d;
  upd_state_e    upd_q, upd_d;
  logic          period_tick_q, period_tick_d;
  logic [CH-1:0] pwm_q, pwm_d;

  pwm_prescaler #(.DIV(DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  // A transfer can only happen while idle, so xfer and load never coincide;
  // a transfer on the wrap cycle therefore waits for the following wrap.
  always_comb begin
    wrap          = tick && (cnt_q == '1);
    xfer          = din_valid && (upd_q == UPD_IDLE);
    load          = (upd_q == UPD_PENDING) && (wrap || !enable);
    period_tick_d = wrap;

    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end

    upd_d = upd_q;
    if (xfer) begin
      upd_d = UPD_PENDING;
    end else if (load) begin
      upd_d = UPD_IDLE;
    end
  end

  assign din_ready   = (upd_q == UPD_IDLE);
  assign pwm_out     = pwm_q;
  assign period_tick = period_tick_q;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [W-1:0] shadow_q, shadow_d;
    logic [W-1:0] active_q, active_d;

    always_comb begin
      shadow_d = shadow_q;
      if (xfer) begin
        shadow_d = W'(to_offset_bin(32'(din[g*SRC_W +: SRC_W]), SRC_W, W));
      end
      active_d = load ? shadow_q : active_q;
    end

    assign pwm_d[g] = enable && (cnt_q < active_q);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadow_q <= '0;
        active_q <= '0;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      upd_q         <= UPD_IDLE;
      period_tick_q <= 1'b0;
      pwm_q         <= '0;
    end else begin
      cnt_q         <= cnt_d;
      upd_q         <= upd_d;
      period_tick_q <= period_tick_d;
      pwm_q         <= pwm_d;
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench: default build (CH=2, SRC_W=16, W=12, DIV=4) plus a small
// CH=1, W=4, DIV=1 build for short-period and same-cycle-wrap scenarios.
module tb_pwm_multi_ch;

  localparam int unsigned PER = 16384;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [1:0]  pwm_out;
  logic        period_tick;

  logic        e4;
  logic [15:0] din4;
  logic        v4;
  logic        r4;
  logic [0:0]  pwm4;
  logic        pt4;

  int checks;
  int errors;

  pwm_multi_ch #(.CH(2), .SRC_W(16), .W(12), .DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  pwm_multi_ch #(.CH(1), .SRC_W(16), .W(4), .DIV(1)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .enable      (e4),
    .din         (din4),
    .din_valid   (v4),
    .din_ready   (r4),
    .pwm_out     (pwm4),
    .period_tick (pt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; din = '0; din_valid = 1'b0;
    e4 = 1'b0; din4 = '0; v4 = 1'b0;
    #1;
    checks++; if (pwm_out !== 2'b00) begin errors++; $display("FAIL reset_pwm got %0d expected 0", pwm_out); end
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL reset_ptick got %0d expected 0", period_tick); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0d expected 1", din_ready); end
    checks++; if (r4 !== 1'b1) begin errors++; $display("FAIL reset_ready4 got %0d expected 1", r4); end
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_div1_w4;
    int hi, ptc, found;
    din4 = 16'hD000; v4 = 1'b1;
    step(1);
    v4 = 1'b0;
    checks++; if (r4 !== 1'b0) begin errors++; $display("FAIL d4_pending got %0d expected 0", r4); end
    step(1);
    checks++; if (r4 !== 1'b1) begin errors++; $display("FAIL d4_load_idle got %0d expected 1", r4); end
    e4 = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step(1);
      if (pt4 === 1'b1) found = 1;
    end
    checks++; if (found != 1) begin errors++; $display("FAIL d4_first_wrap got %0d expected 1", found); end
    hi = 0; ptc = 0;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      hi += int'(pwm4[0]);
      if (k < 16) ptc += int'(pt4);
    end
    checks++; if (hi != 5) begin errors++; $display("FAIL d4_duty5 got %0d expected 5", hi); end
    checks++; if (ptc != 0) begin errors++; $display("FAIL d4_ptick_mid got %0d expected 0", ptc); end
    checks++; if (pt4 !== 1'b1) begin errors++; $display("FAIL d4_ptick_end got %0d expected 1", pt4); end
  endtask

  task automatic test_simultaneous;
    int hi;
    step(15);
    din4 = 16'hA000; v4 = 1'b1;
    step(1);
    v4 = 1'b0;
    checks++; if (pt4 !== 1'b1) begin errors++; $display("FAIL sim_on_wrap got %0d expected 1", pt4); end
    checks++; if (r4 !== 1'b0) begin errors++; $display("FAIL sim_pending got %0d expected 0", r4); end
    hi = 0;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      hi += int'(pwm4[0]);
    end
    checks++; if (hi != 5) begin errors++; $display("FAIL sim_old_duty got %0d expected 5", hi); end
    checks++; if (r4 !== 1'b1) begin errors++; $display("FAIL sim_loaded got %0d expected 1", r4); end
    hi = 0;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      hi += int'(pwm4[0]);
    end
    checks++; if (hi != 2) begin errors++; $display("FAIL sim_new_duty got %0d expected 2", hi); end
    e4 = 1'b0;
  endtask

  task automatic test_conversion;
    int hi0, hi1, ptc, found;
    din = {16'h7FF0, 16'h0000}; din_valid = 1'b1;
    step(1);
    din_valid = 1'b0;
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL conv_pending got %0d expected 0", din_ready); end
    step(1);
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL conv_load_idle got %0d expected 1", din_ready); end
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < PER + 100 && found == 0; i++) begin
      step(1);
      if (period_tick === 1'b1) found = 1;
    end
    checks++; if (found != 1) begin errors++; $display("FAIL conv_first_wrap got %0d expected 1", found); end
    hi0 = 0; hi1 = 0; ptc = 0;
    for (int k = 1; k <= int'(PER); k++) begin
      step(1);
      hi0 += int'(pwm_out[0]);
      hi1 += int'(pwm_out[1]);
      if (k < int'(PER)) ptc += int'(period_tick);
    end
    checks++; if (hi0 != 8192) begin errors++; $display("FAIL conv_ch0 got %0d expected 8192", hi0); end
    checks++; if (hi1 != 16380) begin errors++; $display("FAIL conv_ch1 got %0d expected 16380", hi1); end
    checks++; if (ptc != 0) begin errors++; $display("FAIL conv_ptick_mid got %0d expected 0", ptc); end
    checks++; if (period_tick !== 1'b1) begin errors++; $display("FAIL conv_ptick_period got %0d expected 1", period_tick); end
  endtask

  task automatic test_update_at_wrap;
    int hi0, hi1, late_ready;
    hi0 = 0; hi1 = 0; late_ready = 0;
    for (int k = 1; k <= int'(PER); k++) begin
      if (k == 100) begin
        din = {16'h0000, 16'h8000};
        din_valid = 1'b1;
      end
      step(1);
      if (k == 100) begin
        din_valid = 1'b0;
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL upd_pending got %0d expected 0", din_ready); end
      end
      if (k > 100 && k < int'(PER)) late_ready += int'(din_ready);
      hi0 += int'(pwm_out[0]);
      hi1 += int'(pwm_out[1]);
    end
    checks++; if (late_ready != 0) begin errors++; $display("FAIL upd_ready_early got %0d expected 0", late_ready); end
    checks++; if (hi0 != 8192) begin errors++; $display("FAIL upd_old_ch0 got %0d expected 8192", hi0); end
    checks++; if (hi1 != 16380) begin errors++; $display("FAIL upd_old_ch1 got %0d expected 16380", hi1); end
    checks++; if (period_tick !== 1'b1) begin errors++; $display("FAIL upd_ptick got %0d expected 1", period_tick); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL upd_ready_wrap got %0d expected 1", din_ready); end
  endtask

  task automatic test_extremes;
    int hi0, hi1, ptc;
    hi0 = 0; hi1 = 0; ptc = 0;
    for (int k = 1; k <= int'(PER); k++) begin
      step(1);
      hi0 += int'(pwm_out[0]);
      hi1 += int'(pwm_out[1]);
      if (k < int'(PER)) ptc += int'(period_tick);
    end
    checks++; if (hi0 != 0) begin errors++; $display("FAIL ext_ch0_zero got %0d expected 0", hi0); end
    checks++; if (hi1 != 8192) begin errors++; $display("FAIL ext_ch1_mid got %0d expected 8192", hi1); end
    checks++; if (ptc != 0) begin errors++; $display("FAIL ext_ptick_mid got %0d expected 0", ptc); end
    checks++; if (period_tick !== 1'b1) begin errors++; $display("FAIL ext_ptick_period got %0d expected 1", period_tick); end
  endtask

  task automatic test_reset_mid;
    int hi0, hi1;
    step(10);
    din = {16'h1230, 16'h4560}; din_valid = 1'b1;
    step(1);
    din_valid = 1'b0;
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL rstm_pending got %0d expected 0", din_ready); end
    step(4096 - 11);
    rst = 1'b1;
    #1;
    checks++; if (pwm_out !== 2'b00) begin errors++; $display("FAIL rstm_pwm got %0d expected 0", pwm_out); end
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL rstm_ptick got %0d expected 0", period_tick); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL rstm_ready got %0d expected 1", din_ready); end
    step(2);
    rst = 1'b0;
    enable = 1'b0;
    step(3);
    enable = 1'b1;
    hi0 = 0; hi1 = 0;
    for (int k = 1; k <= 64; k++) begin
      step(1);
      hi0 += int'(pwm_out[0]);
      hi1 += int'(pwm_out[1]);
    end
    checks++; if (hi0 + hi1 != 0) begin errors++; $display("FAIL rstm_discard got %0d expected 0", hi0 + hi1); end
    enable = 1'b0;
    din = {16'h8020, 16'h8010}; din_valid = 1'b1;
    step(1);
    din_valid = 1'b0;
    step(1);
    enable = 1'b1;
    step(1);
    checks++; if (pwm_out !== 2'b11) begin errors++; $display("FAIL rstm_first got %0d expected 3", pwm_out); end
    hi0 = int'(pwm_out[0]); hi1 = int'(pwm_out[1]);
    for (int k = 2; k <= 16; k++) begin
      step(1);
      hi0 += int'(pwm_out[0]);
      hi1 += int'(pwm_out[1]);
    end
    checks++; if (hi0 != 4) begin errors++; $display("FAIL rstm_restart_ch0 got %0d expected 4", hi0); end
    checks++; if (hi1 != 8) begin errors++; $display("FAIL rstm_restart_ch1 got %0d expected 8", hi1); end
    enable = 1'b0;
    step(2);
    checks++; if (pwm_out !== 2'b00) begin errors++; $display("FAIL stop_pwm got %0d expected 0", pwm_out); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_div1_w4();
    test_simultaneous();
    test_conversion();
    test_update_at_wrap();
    test_extremes();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
